zap_wb_fabric: RTL and testbench
================================

Name: zap_wb_fabric

Overview:
Parametrised Wishbone B3 address decoder/router between one master (the ZAP core data port) and NUM_SLAVES slaves.
- Address windows come from parameters.
- The slave selection is locked for the whole CYC span, so bursts cannot split across slaves.
- Returns a bus error for unmapped accesses and for slaves that never acknowledge (timeout).
- Captures the faulting address for software and raises an interrupt.
- Sits between zap_top and the peripheral/RAM slaves. It replaces the ad-hoc combinational if/else decode at SoC level.

Parameters:
- NUM_SLAVES, 8, number of slave ports (1..16).
- SLAVE_BASE, {NUM_SLAVES{32'h0}}, packed 32*NUM_SLAVES; base address of slave k is bits [32k+31:32k].
- SLAVE_MASK, {NUM_SLAVES{32'hFFFFFFFF}}, packed; slave k matches when (adr & MASK_k) == (BASE_k & MASK_k).
- DEFAULT_SLAVE, NUM_SLAVES-1, port taken on no match; value NUM_SLAVES means none, so an unmapped access returns an error.
- TIMEOUT_CYCLES, 255, maximum consecutive STB cycles without ACK/ERR before a timeout error; 0 disables timeout.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous active-high reset
- i_wb_cyc  in  1  master cycle
- i_wb_stb  in  1  master strobe
- i_wb_adr  in  32  master address
- i_wb_cti  in  3  master cycle type (monitored only)
- o_wb_ack  out  1  ack to master
- o_wb_err  out  1  error to master
- o_wb_dat  out  32  read data to master
- o_s_cyc  out  NUM_SLAVES  per-slave cycle
- o_s_stb  out  NUM_SLAVES  per-slave strobe
- i_s_ack  in  NUM_SLAVES  per-slave ack
- i_s_err  in  NUM_SLAVES  per-slave error
- i_s_dat  in  32*NUM_SLAVES  per-slave read data, packed
- i_err_clr  in  1  clears captured error status
- o_err_valid  out  1  sticky: an error was generated
- o_err_adr  out  32  address of the first error since clear
- o_err_code  out  2  01 unmapped, 10 timeout, 11 slave error
- o_err_irq  out  1  equals o_err_valid

Adr/we/sel/dat to slaves are broadcast outside this block.

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0; error capture cleared.
- Decode: the lowest-index matching slave wins. With no match, DEFAULT_SLAVE is used; if DEFAULT_SLAVE == NUM_SLAVES, the access is unmapped.
- State IDLE:
  - On i_wb_cyc&i_wb_stb with a mapped decode, drive the decoded slave's cyc/stb in the same cycle (zero added latency). Register the slave index and go to ACTIVE.
  - If that slave acks in the same cycle, the ack passes straight through.
  - If unmapped, go to UNMAP. No slave is strobed.
- State ACTIVE:
  - o_s_cyc[sel] = i_wb_cyc and o_s_stb[sel] = i_wb_stb, using the locked index regardless of i_wb_adr changes.
  - o_wb_ack = i_s_ack[sel]; o_wb_dat = i_s_dat[sel]; o_wb_err = i_s_err[sel].
  - When i_wb_cyc is 0, go to IDLE.
  - All unselected slaves hold cyc/stb = 0.
- State UNMAP: assert o_wb_err for exactly 1 cycle (one cycle after the strobe), then go to DRAIN.
- State DRAIN:
  - All slave cyc/stb = 0; o_wb_ack = o_wb_err = 0.
  - Return to IDLE when i_wb_cyc = 0. If i_wb_cyc is already 0, return on the next cycle.
- Timeout (ACTIVE only, TIMEOUT_CYCLES > 0):
  - Counter increments each cycle with i_wb_stb=1 and no ack/err.
  - Counter clears on ack, err, stb=0, or state change.
  - When the counter equals TIMEOUT_CYCLES-1 and no ack/err arrives, next cycle: o_wb_err=1 for 1 cycle, slave cyc/stb forced 0, go to DRAIN.
  - A late slave ack in DRAIN is ignored.
- Error capture:
  - On any generated o_wb_err (unmapped, timeout, or passed-through slave error), if o_err_valid=0: latch o_err_adr and o_err_code, and set o_err_valid.
  - Later errors do not overwrite the capture.
  - i_err_clr clears o_err_valid, o_err_adr and o_err_code next cycle. If a new error coincides with clear, the new error wins and is captured.
- ack and err are never asserted in the same cycle to the master. If a slave drives both, err wins and ack is masked.
- o_wb_dat is 0 whenever no slave is selected.
- Reset mid-transaction: immediately IDLE with all cyc/stb 0 next cycle; capture cleared.

Test Plan:
1. NUM_SLAVES=4, BASE1=FFFEFFE0, MASK1=FFFFFFE0. Read FFFEFFE4, slave1 acks after 2 cycles with data 0xA5 -> o_s_stb=0010; o_wb_ack with o_wb_dat=0x000000A5; no other slave strobed.
2. Incrementing burst (cti=010, 4 beats) starting inside slave1's window, address crossing into slave2's window on beat 3 -> all 4 beats routed to slave1; o_s_cyc[2] never asserted.
3. DEFAULT_SLAVE=4 (none), access 0x12345678 -> no slave strobed; o_wb_err pulses 1 cycle after stb; o_err_code=01, o_err_adr=0x12345678, o_err_irq=1.
4. TIMEOUT_CYCLES=8, slave0 never acks -> o_wb_err exactly 8 cycles after first stb; o_s_cyc[0] drops the same cycle; o_err_code=10; a late ack 3 cycles later produces no o_wb_ack.
5. Error pending, then second error at a different address -> capture unchanged. Pulse i_err_clr -> o_err_valid=0 next cycle. Clear coincident with a new error -> new address captured.
6. Assert i_reset during ACTIVE with stb high -> next cycle all o_s_cyc/o_s_stb=0, o_wb_ack/err=0, state IDLE; a following access decodes normally.

Source files
------------

// File: rtl/zap_wb_fabric.sv
`default_nettype none
// ============================================================================
//  Module   : zap_wb_fabric
//  Purpose  : Wishbone B3 address decoder/router from one master (ZAP core
//             data port) to NUM_SLAVES slaves. The slave chosen at the start
//             of a CYC span stays locked for the whole span. Unmapped accesses
//             and stalled slaves (timeout) get a bus error. The first error
//             since the last clear is captured for software and raises an IRQ.
//  Ports    : i_clk, i_reset        - clock, synchronous active-high reset
//             i_wb_cyc/stb/adr/cti  - master request (cti is monitored only)
//             o_wb_ack/err/dat      - master response
//             o_s_cyc/o_s_stb       - per-slave cycle/strobe (one-hot)
//             i_s_ack/err/dat       - per-slave response, dat packed 32*N
//             i_err_clr             - clears the captured error status
//             o_err_valid/adr/code  - captured error (code 01 unmapped,
//                                     10 timeout, 11 slave error)
//             o_err_irq             - interrupt, equals o_err_valid
//  Revision : 1.0 - initial release
// ============================================================================
module zap_wb_fabric #(
  parameter int                        NUM_SLAVES     = 8,
  parameter logic [32*NUM_SLAVES-1:0]  SLAVE_BASE     = {NUM_SLAVES{32'h0}},
  parameter logic [32*NUM_SLAVES-1:0]  SLAVE_MASK     = {NUM_SLAVES{32'hFFFF_FFFF}},
  parameter int                        DEFAULT_SLAVE  = NUM_SLAVES-1,
  parameter int                        TIMEOUT_CYCLES = 255
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_wb_cyc,
  input  logic                       i_wb_stb,
  input  logic [31:0]                i_wb_adr,
  input  logic [2:0]                 i_wb_cti,
  output logic                       o_wb_ack,
  output logic                       o_wb_err,
  output logic [31:0]                o_wb_dat,
  output logic [NUM_SLAVES-1:0]      o_s_cyc,
  output logic [NUM_SLAVES-1:0]      o_s_stb,
  input  logic [NUM_SLAVES-1:0]      i_s_ack,
  input  logic [NUM_SLAVES-1:0]      i_s_err,
  input  logic [32*NUM_SLAVES-1:0]   i_s_dat,
  input  logic                       i_err_clr,
  output logic                       o_err_valid,
  output logic [31:0]                o_err_adr,
  output logic [1:0]                 o_err_code,
  output logic                       o_err_irq
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit               HAS_DEFAULT = (DEFAULT_SLAVE < NUM_SLAVES);
  localparam logic [IDX_W-1:0] DEFAULT_IDX =
    IDX_W'((DEFAULT_SLAVE < NUM_SLAVES) ? DEFAULT_SLAVE : 0);

  localparam logic [1:0] CODE_UNMAP   = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;
  localparam logic [1:0] CODE_SLAVE   = 2'b11;

  // ST_ERR issues the one-cycle error pulse for both unmapped accesses and
  // timeouts; err_kind records which one it was.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERR    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  sel, sel_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [1:0]        err_kind, kind_nx;
  logic [31:0]       fault_adr, fadr_nx;

  logic              err_valid_q;
  logic [31:0]       err_adr_q;
  logic [1:0]        err_code_q;

  logic              dec_hit;
  logic [IDX_W-1:0]  dec_idx;
  logic              dec_mapped;
  logic [IDX_W-1:0]  dec_sel;

  logic              route;
  logic [IDX_W-1:0]  tgt;
  logic [NUM_SLAVES-1:0] s_cyc, s_stb;
  logic              wb_ack, wb_err;
  logic [31:0]       wb_dat;
  logic              err_event;
  logic [1:0]        err_event_code;
  logic [31:0]       err_event_adr;

  logic              unused_cti;
  assign unused_cti = ^i_wb_cti;

  // Address decode: scanning downwards leaves the lowest matching index.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int k = NUM_SLAVES-1; k >= 0; k--) begin
      if ((i_wb_adr & SLAVE_MASK[32*k +: 32]) ==
          (SLAVE_BASE[32*k +: 32] & SLAVE_MASK[32*k +: 32])) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(k);
      end
    end
  end

  assign dec_mapped = dec_hit | HAS_DEFAULT;
  assign dec_sel    = dec_hit ? dec_idx : DEFAULT_IDX;

  always_comb begin
    state_nx       = state;
    sel_nx         = sel;
    cnt_nx         = '0;
    kind_nx        = err_kind;
    fadr_nx        = fault_adr;
    route          = 1'b0;
    tgt            = sel;
    s_cyc          = '0;
    s_stb          = '0;
    wb_ack         = 1'b0;
    wb_err         = 1'b0;
    wb_dat         = '0;
    err_event      = 1'b0;
    err_event_code = CODE_SLAVE;
    err_event_adr  = i_wb_adr;

    case (state)
      ST_IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          if (dec_mapped) begin
            // Zero-latency launch: strobe the decoded slave this very cycle.
            route    = 1'b1;
            tgt      = dec_sel;
            sel_nx   = dec_sel;
            state_nx = ST_ACTIVE;
          end else begin
            state_nx = ST_ERR;
            kind_nx  = CODE_UNMAP;
            fadr_nx  = i_wb_adr;
          end
        end
      end
      ST_ACTIVE: begin
        route = 1'b1;
        if (!i_wb_cyc) state_nx = ST_IDLE;
      end
      ST_ERR: begin
        wb_err         = 1'b1;
        err_event      = 1'b1;
        err_event_code = err_kind;
        err_event_adr  = fault_adr;
        state_nx       = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!i_wb_cyc) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase

    if (route) begin
      s_cyc[tgt] = i_wb_cyc;
      s_stb[tgt] = i_wb_stb;
      wb_err     = i_s_err[tgt];
      wb_ack     = i_s_ack[tgt] & ~i_s_err[tgt];
      wb_dat     = i_s_dat[32*tgt +: 32];
      err_event  = i_s_err[tgt];
      // The launch cycle counts as the first stalled strobe, so the error
      // lands exactly TIMEOUT_CYCLES cycles after the first strobe.
      if ((TIMEOUT_CYCLES > 0) && i_wb_stb && !i_s_ack[tgt] && !i_s_err[tgt]) begin
        if (cnt == CNT_LAST) begin
          state_nx = ST_ERR;
          kind_nx  = CODE_TIMEOUT;
          fadr_nx  = i_wb_adr;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      sel       <= '0;
      cnt       <= '0;
      err_kind  <= CODE_UNMAP;
      fault_adr <= '0;
    end else begin
      state     <= state_nx;
      sel       <= sel_nx;
      cnt       <= cnt_nx;
      err_kind  <= kind_nx;
      fault_adr <= fadr_nx;
    end
  end

  // A new error in the same cycle as a clear wins over the clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      err_valid_q <= 1'b0;
      err_adr_q   <= '0;
      err_code_q  <= '0;
    end else if (err_event && (!err_valid_q || i_err_clr)) begin
      err_valid_q <= 1'b1;
      err_adr_q   <= err_event_adr;
      err_code_q  <= err_event_code;
    end else if (i_err_clr) begin
      err_valid_q <= 1'b0;
      err_adr_q   <= '0;
      err_code_q  <= '0;
    end
  end

  // Bus outputs are held low while reset is asserted.
  assign o_s_cyc     = i_reset ? '0   : s_cyc;
  assign o_s_stb     = i_reset ? '0   : s_stb;
  assign o_wb_ack    = i_reset ? 1'b0 : wb_ack;
  assign o_wb_err    = i_reset ? 1'b0 : wb_err;
  assign o_wb_dat    = i_reset ? '0   : wb_dat;
  assign o_err_valid = err_valid_q;
  assign o_err_adr   = err_adr_q;
  assign o_err_code  = err_code_q;
  assign o_err_irq   = err_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_zap_wb_fabric.sv
`default_nettype none
// ============================================================================
//  Module   : tb_zap_wb_fabric
//  Purpose  : Directed bench for zap_wb_fabric with a span-level reference
//             model checked every cycle plus hand-computed literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_zap_wb_fabric;

  localparam int NS  = 4;
  localparam int TMO = 8;
  localparam logic [32*NS-1:0] BASES =
    {32'h2000_0000, 32'hFFFF_0000, 32'hFFFE_FFE0, 32'h0000_0000};
  localparam logic [32*NS-1:0] MASKS =
    {32'hF000_0000, 32'hFFFF_FFE0, 32'hFFFF_FFE0, 32'hFFFF_0000};

  logic              clk = 1'b0;
  logic              rst;
  logic              cyc, stb;
  logic [31:0]       adr;
  logic [2:0]        cti;
  logic              o_wb_ack, o_wb_err;
  logic [31:0]       o_wb_dat;
  logic [NS-1:0]     o_s_cyc, o_s_stb;
  logic [NS-1:0]     s_ack, s_err;
  logic [32*NS-1:0]  s_dat;
  logic              err_clr;
  logic              o_err_valid, o_err_irq;
  logic [31:0]       o_err_adr;
  logic [1:0]        o_err_code;

  always #5 clk = ~clk;

  zap_wb_fabric #(
    .NUM_SLAVES     (NS),
    .SLAVE_BASE     (BASES),
    .SLAVE_MASK     (MASKS),
    .DEFAULT_SLAVE  (NS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_wb_cyc    (cyc),
    .i_wb_stb    (stb),
    .i_wb_adr    (adr),
    .i_wb_cti    (cti),
    .o_wb_ack    (o_wb_ack),
    .o_wb_err    (o_wb_err),
    .o_wb_dat    (o_wb_dat),
    .o_s_cyc     (o_s_cyc),
    .o_s_stb     (o_s_stb),
    .i_s_ack     (s_ack),
    .i_s_err     (s_err),
    .i_s_dat     (s_dat),
    .i_err_clr   (err_clr),
    .o_err_valid (o_err_valid),
    .o_err_adr   (o_err_adr),
    .o_err_code  (o_err_code),
    .o_err_irq   (o_err_irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Lowest-index window match; -1 means unmapped (no default slave here).
  function automatic int decode(input logic [31:0] a);
    logic [31:0] b, m;
    decode = -1;
    for (int k = NS-1; k >= 0; k--) begin
      b = BASES[32*k +: 32];
      m = MASKS[32*k +: 32];
      if ((a & m) == (b & m)) decode = k;
    end
  endfunction

  // ---------------- span-level reference model ----------------
  // A span begins at the first strobe seen outside a span and belongs to one
  // owner for its lifetime. Once an error has been reported the span is dead
  // until the master drops CYC.
  bit          m_open, m_dead, m_pend;
  int          m_owner, m_run;
  logic [1:0]  m_pcode;
  logic [31:0] m_padr;
  bit          c_valid;
  logic [31:0] c_adr;
  logic [1:0]  c_code;

  initial begin
    m_open = 0; m_dead = 0; m_pend = 0; m_owner = -1; m_run = 0;
    m_pcode = 0; m_padr = 0; c_valid = 0; c_adr = 0; c_code = 0;
  end

  always @(negedge clk) begin
    logic [NS-1:0] e_cyc, e_stb;
    logic          e_ack, e_err;
    logic [31:0]   e_dat, e_adr;
    logic [1:0]    e_code;
    logic          sa, se, fire;
    int            k;

    chk("cap_valid", o_err_valid, c_valid);
    chk("cap_irq",   o_err_irq,   c_valid);
    chk("cap_adr",   o_err_adr,   c_adr);
    chk("cap_code",  o_err_code,  c_code);

    e_cyc = '0; e_stb = '0; e_ack = 0; e_err = 0; e_dat = '0;
    e_code = 2'b11; e_adr = adr;

    if (rst) begin
      m_open = 0; m_dead = 0; m_pend = 0; m_run = 0;
      c_valid = 0; c_adr = '0; c_code = '0;
    end else begin
      fire   = m_pend;
      m_pend = 0;
      if (!m_open && cyc && stb) begin
        m_open = 1; m_dead = 0; m_run = 0; m_owner = decode(adr);
      end
      if (fire) begin
        e_err = 1; e_code = m_pcode; e_adr = m_padr; m_dead = 1;
      end else if (m_open && m_dead) begin
        if (!cyc) m_open = 0;
      end else if (m_open && m_owner < 0) begin
        m_pend = 1; m_pcode = 2'b01; m_padr = adr;
      end else if (m_open) begin
        k  = m_owner;
        sa = s_ack[k];
        se = s_err[k];
        e_cyc[k] = cyc;
        e_stb[k] = stb;
        e_err    = se;
        e_ack    = sa & !se;
        e_dat    = s_dat[32*k +: 32];
        if (stb && !sa && !se) begin
          m_run++;
          if (m_run == TMO) begin
            m_pend = 1; m_pcode = 2'b10; m_padr = adr;
          end
        end else begin
          m_run = 0;
        end
        if (!cyc && !m_pend) m_open = 0;
      end
    end

    chk("s_cyc",  o_s_cyc,  e_cyc);
    chk("s_stb",  o_s_stb,  e_stb);
    chk("wb_ack", o_wb_ack, e_ack);
    chk("wb_err", o_wb_err, e_err);
    chk("wb_dat", o_wb_dat, e_dat);

    if (!rst) begin
      if (e_err && (!c_valid || err_clr)) begin
        c_valid = 1; c_adr = e_adr; c_code = e_code;
      end else if (err_clr) begin
        c_valid = 0; c_adr = '0; c_code = '0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic neg;
    @(negedge clk);
  endtask

  initial begin
    rst = 1; cyc = 0; stb = 0; adr = '0; cti = '0;
    s_ack = '0; s_err = '0; err_clr = 0;
    s_dat = {32'h3333_3333, 32'h2222_2222, 32'h0000_00A5, 32'h0000_1000};
    step; step;
    neg; chk("rst_s_cyc", o_s_cyc, 4'b0000); chk("rst_err_valid", o_err_valid, 1'b0);
    step; rst = 0;
    step;

    // Read from slave 1, ack after 2 cycles.
    step; cyc = 1; stb = 1; adr = 32'hFFFE_FFE4;
    neg; chk("t1_stb_onehot", o_s_stb, 4'b0010); chk("t1_no_ack_yet", o_wb_ack, 1'b0);
    step;
    step; s_ack = 4'b0010;
    neg; chk("t1_ack", o_wb_ack, 1'b1); chk("t1_dat", o_wb_dat, 32'h0000_00A5);
    step; cyc = 0; stb = 0; s_ack = '0;
    step;

    // Incrementing burst crossing from slave 1's window into slave 2's.
    step; cyc = 1; stb = 1; cti = 3'b010; adr = 32'hFFFE_FFF8; s_ack = 4'b0010;
    neg; chk("t2_beat0_ack", o_wb_ack, 1'b1);
    step; adr = 32'hFFFE_FFFC;
    step; adr = 32'hFFFF_0000;
    neg; chk("t2_beat2_cyc", o_s_cyc, 4'b0010); chk("t2_beat2_dat", o_wb_dat, 32'h0000_00A5);
    step; adr = 32'hFFFF_0004; cti = 3'b111;
    neg; chk("t2_beat3_ack", o_wb_ack, 1'b1);
    step; cyc = 0; stb = 0; s_ack = '0; cti = '0;
    step;

    // Unmapped access.
    step; cyc = 1; stb = 1; adr = 32'h1234_5678;
    neg; chk("t3_no_strobe", o_s_stb, 4'b0000); chk("t3_no_err_yet", o_wb_err, 1'b0);
    step;
    neg; chk("t3_err_pulse", o_wb_err, 1'b1); chk("t3_no_cyc", o_s_cyc, 4'b0000);
    step; cyc = 0; stb = 0;
    neg; chk("t3_err_single", o_wb_err, 1'b0); chk("t3_code", o_err_code, 2'b01);
    chk("t3_adr", o_err_adr, 32'h1234_5678); chk("t3_irq", o_err_irq, 1'b1);
    step;

    // Timeout while an error is already captured.
    step; cyc = 1; stb = 1; adr = 32'h0000_0040;
    repeat (7) step;
    neg; chk("t4a_cyc_held", o_s_cyc, 4'b0001); chk("t4a_no_err_early", o_wb_err, 1'b0);
    step;
    neg; chk("t4a_timeout_err", o_wb_err, 1'b1); chk("t4a_cyc_drop", o_s_cyc, 4'b0000);
    step; cyc = 0; stb = 0;
    step;
    neg; chk("t5_kept_adr", o_err_adr, 32'h1234_5678); chk("t5_kept_code", o_err_code, 2'b01);

    // Slave drives ack and err together.
    step; cyc = 1; stb = 1; adr = 32'h2000_0004; s_ack = 4'b1000; s_err = 4'b1000;
    neg; chk("t5_err_wins", o_wb_err, 1'b1); chk("t5_ack_masked", o_wb_ack, 1'b0);
    step; cyc = 0; stb = 0; s_ack = '0; s_err = '0;
    step;
    neg; chk("t5_still_kept", o_err_adr, 32'h1234_5678);

    // Clear.
    step; err_clr = 1;
    step; err_clr = 0;
    neg; chk("t5_clr_valid", o_err_valid, 1'b0); chk("t5_clr_adr", o_err_adr, 32'h0);

    // Timeout with empty capture, then a late ack.
    step; cyc = 1; stb = 1; adr = 32'h0000_0080;
    repeat (8) step;
    neg; chk("t4b_timeout_err", o_wb_err, 1'b1);
    step; stb = 0;
    neg; chk("t4b_code", o_err_code, 2'b10); chk("t4b_adr", o_err_adr, 32'h0000_0080);
    step;
    step; s_ack = 4'b0001;
    neg; chk("t4b_late_ack_ignored", o_wb_ack, 1'b0); chk("t4b_late_no_cyc", o_s_cyc, 4'b0000);
    step; cyc = 0; s_ack = '0;
    step;

    // Clear coincident with a new unmapped error.
    step; cyc = 1; stb = 1; adr = 32'h7000_0010;
    step; err_clr = 1;
    step; err_clr = 0; cyc = 0; stb = 0;
    neg; chk("t5c_valid", o_err_valid, 1'b1); chk("t5c_adr", o_err_adr, 32'h7000_0010);
    chk("t5c_code", o_err_code, 2'b01);
    step;

    // Reset in the middle of an active transfer.
    step; cyc = 1; stb = 1; adr = 32'hFFFF_0004;
    step;
    neg; chk("t6_active", o_s_stb, 4'b0100);
    step; rst = 1;
    step; rst = 0; cyc = 0; stb = 0;
    neg; chk("t6_cyc_zero", o_s_cyc, 4'b0000); chk("t6_stb_zero", o_s_stb, 4'b0000);
    chk("t6_err_zero", o_wb_err, 1'b0); chk("t6_cap_cleared", o_err_valid, 1'b0);
    step; cyc = 1; stb = 1; adr = 32'h0000_0010; s_ack = 4'b0001;
    neg; chk("t6_after_ack", o_wb_ack, 1'b1); chk("t6_after_dat", o_wb_dat, 32'h0000_1000);
    chk("t6_after_cyc", o_s_cyc, 4'b0001);
    step; cyc = 0; stb = 0; s_ack = '0;
    step; step;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
